// File: rtl/jpeg_axil_master_if.sv
// Bundle of the command/response port and the AXI4-Lite bus driven by jpeg_axil_master.
// The master modport is the initiator's view; the slave modport is the environment's view.
interface jpeg_axil_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [3:0]            cmd_wstrb;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0]            rsp_resp;
  logic                  rsp_timeout;

  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [2:0]            m_axi_awprot;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic [3:0]            m_axi_wstrb;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [2:0]            m_axi_arprot;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    input  rsp_ready,
    output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    output rsp_ready,
    input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/jpeg_axil_master.sv
// Single-outstanding AXI4-Lite initiator turning register commands into bus transactions.
// Define AXIL_TIMEOUT_EN to build the watchdog that aborts a stalled transaction.
module jpeg_axil_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  jpeg_axil_master_if.master   bus,
  output logic [2:0]           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; a raised valid and its payload never change until that transfer occurs.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   aw_fire;
  logic   w_fire;

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("jpeg_axil_master: TIMEOUT_CYCLES must be at least 2");
  end

  assign bus.m_axi_awprot = 3'b000;
  assign bus.m_axi_arprot = 3'b000;
  assign dbg_state        = state;

  assign aw_fire = bus.m_axi_awvalid && bus.m_axi_awready;
  assign w_fire  = bus.m_axi_wvalid  && bus.m_axi_wready;

`ifdef AXIL_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wd_cnt;
  logic             busy;
  logic             any_fire;
  logic             wd_expired;
  logic             timeout_q;

  assign busy     = (state == WADDR) || (state == WRESP) ||
                    (state == RADDR) || (state == RDATA);
  assign any_fire = aw_fire || w_fire ||
                    (bus.m_axi_bvalid  && bus.m_axi_bready)  ||
                    (bus.m_axi_arvalid && bus.m_axi_arready) ||
                    (bus.m_axi_rvalid  && bus.m_axi_rready);
  assign wd_expired = busy && !any_fire && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus.rsp_timeout = timeout_q;

  // Idle and response states hold the counter at zero, so entry to a bus state starts at 0.
  always_ff @(posedge clk) begin
    if (reset || !busy || any_fire || wd_expired) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign bus.rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      aw_done           <= 1'b0;
      w_done            <= 1'b0;
      bus.cmd_ready     <= 1'b0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_rdata     <= {DATA_WIDTH{1'b0}};
      bus.rsp_resp      <= 2'b00;
      bus.m_axi_awaddr  <= {ADDR_WIDTH{1'b0}};
      bus.m_axi_awvalid <= 1'b0;
      bus.m_axi_wdata   <= {DATA_WIDTH{1'b0}};
      bus.m_axi_wstrb   <= 4'h0;
      bus.m_axi_wvalid  <= 1'b0;
      bus.m_axi_bready  <= 1'b0;
      bus.m_axi_araddr  <= {ADDR_WIDTH{1'b0}};
      bus.m_axi_arvalid <= 1'b0;
      bus.m_axi_rready  <= 1'b0;
`ifdef AXIL_TIMEOUT_EN
      timeout_q         <= 1'b0;
`endif
    end
`ifdef AXIL_TIMEOUT_EN
    // Debug recovery: abandons the transaction even if a valid is still waiting.
    else if (wd_expired) begin
      state             <= RESP;
      bus.m_axi_awvalid <= 1'b0;
      bus.m_axi_wvalid  <= 1'b0;
      bus.m_axi_bready  <= 1'b0;
      bus.m_axi_arvalid <= 1'b0;
      bus.m_axi_rready  <= 1'b0;
      bus.rsp_valid     <= 1'b1;
      bus.rsp_resp      <= 2'b10;
      bus.rsp_rdata     <= {DATA_WIDTH{1'b0}};
      timeout_q         <= 1'b1;
    end
`endif
    else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_ready <= 1'b0;
            if (bus.cmd_write) begin
              bus.m_axi_awaddr  <= bus.cmd_addr;
              bus.m_axi_wdata   <= bus.cmd_wdata;
              bus.m_axi_wstrb   <= bus.cmd_wstrb;
              bus.m_axi_awvalid <= 1'b1;
              bus.m_axi_wvalid  <= 1'b1;
              aw_done           <= 1'b0;
              w_done            <= 1'b0;
              state             <= WADDR;
            end else begin
              bus.m_axi_araddr  <= bus.cmd_addr;
              bus.m_axi_arvalid <= 1'b1;
              state             <= RADDR;
            end
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end

        WADDR: begin
          if (aw_fire) begin
            bus.m_axi_awvalid <= 1'b0;
            aw_done           <= 1'b1;
          end
          if (w_fire) begin
            bus.m_axi_wvalid <= 1'b0;
            w_done           <= 1'b1;
          end
          // AW and W may land in either order or together.
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            bus.m_axi_bready <= 1'b1;
            state            <= WRESP;
          end
        end

        WRESP: begin
          if (bus.m_axi_bvalid) begin
            bus.m_axi_bready <= 1'b0;
            bus.rsp_resp     <= bus.m_axi_bresp;
            bus.rsp_rdata    <= {DATA_WIDTH{1'b0}};
            bus.rsp_valid    <= 1'b1;
            state            <= RESP;
          end
        end

        RADDR: begin
          if (bus.m_axi_arready) begin
            bus.m_axi_arvalid <= 1'b0;
            bus.m_axi_rready  <= 1'b1;
            state             <= RDATA;
          end
        end

        RDATA: begin
          if (bus.m_axi_rvalid) begin
            bus.m_axi_rready <= 1'b0;
            bus.rsp_rdata    <= bus.m_axi_rdata;
            bus.rsp_resp     <= bus.m_axi_rresp;
            bus.rsp_valid    <= 1'b1;
            state            <= RESP;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
`ifdef AXIL_TIMEOUT_EN
            timeout_q     <= 1'b0;
`endif
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_axil_master.sv
// Directed bench for jpeg_axil_master: hand-computed cycle-by-cycle expectations
// for writes, reads, split AW/W acceptance, response backpressure, reset and watchdog.
module tb_jpeg_axil_master;

  localparam int AW = 8;
  localparam int DW = 32;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WADDR = 3'd1;
  localparam logic [2:0] S_WRESP = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd5;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;
  int         total;
  int         bad;
  int         n;

  jpeg_axil_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  jpeg_axil_master #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [3:0] strb);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = data;
    bus.cmd_wstrb = strb;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.cmd_valid     = 1'b0;
    bus.cmd_write     = 1'b0;
    bus.cmd_addr      = '0;
    bus.cmd_wdata     = '0;
    bus.cmd_wstrb     = '0;
    bus.rsp_ready     = 1'b1;
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;
    bus.m_axi_bresp   = 2'b00;
    bus.m_axi_bvalid  = 1'b0;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rdata   = '0;
    bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rvalid  = 1'b0;

    // reset state
    repeat (3) tick();
    chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk("rst_awvalid", bus.m_axi_awvalid, 1'b0);
    chk("rst_wvalid", bus.m_axi_wvalid, 1'b0);
    chk("rst_arvalid", bus.m_axi_arvalid, 1'b0);
    chk("rst_bready", bus.m_axi_bready, 1'b0);
    chk("rst_rready", bus.m_axi_rready, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_timeout", bus.rsp_timeout, 1'b0);
    chk("rst_state", dbg_state, S_IDLE);
    chk("rst_prot", {bus.m_axi_awprot, bus.m_axi_arprot}, 6'b0);
    reset = 1'b0;
    tick();
    chk("idle_cmd_ready", bus.cmd_ready, 1'b1);

    // write with zero-wait slave
    drive_cmd(1'b1, 8'h04, 32'hDEADBEEF, 4'hF);
    bus.m_axi_awready = 1'b1;
    bus.m_axi_wready  = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    chk("w1_c1_awvalid", bus.m_axi_awvalid, 1'b1);
    chk("w1_c1_wvalid", bus.m_axi_wvalid, 1'b1);
    chk("w1_c1_awaddr", bus.m_axi_awaddr, 8'h04);
    chk("w1_c1_wdata", bus.m_axi_wdata, 32'hDEADBEEF);
    chk("w1_c1_wstrb", bus.m_axi_wstrb, 4'hF);
    chk("w1_c1_cmd_ready", bus.cmd_ready, 1'b0);
    chk("w1_c1_state", dbg_state, S_WADDR);
    tick();
    chk("w1_c2_awvalid", bus.m_axi_awvalid, 1'b0);
    chk("w1_c2_wvalid", bus.m_axi_wvalid, 1'b0);
    chk("w1_c2_bready", bus.m_axi_bready, 1'b1);
    chk("w1_c2_rsp_valid", bus.rsp_valid, 1'b0);
    bus.m_axi_bvalid = 1'b1;
    bus.m_axi_bresp  = 2'b00;
    tick();
    bus.m_axi_bvalid = 1'b0;
    chk("w1_c3_rsp_valid", bus.rsp_valid, 1'b1);
    chk("w1_c3_rsp_resp", bus.rsp_resp, 2'b00);
    chk("w1_c3_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("w1_c3_bready", bus.m_axi_bready, 1'b0);
    chk("w1_c3_timeout", bus.rsp_timeout, 1'b0);
    tick();
    chk("w1_c4_rsp_valid", bus.rsp_valid, 1'b0);
    chk("w1_c4_cmd_ready", bus.cmd_ready, 1'b1);
    chk("w1_c4_state", dbg_state, S_IDLE);

    // read with arready delayed three cycles
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;
    drive_cmd(1'b0, 8'h08, 32'h0, 4'h0);
    tick();
    bus.cmd_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.m_axi_arvalid) n++;
      chk("r1_araddr", bus.m_axi_araddr, 8'h08);
      chk("r1_rready_low", bus.m_axi_rready, 1'b0);
      tick();
    end
    bus.m_axi_arready = 1'b1;
    if (bus.m_axi_arvalid) n++;
    tick();
    bus.m_axi_arready = 1'b0;
    chk("r1_arvalid_cycles", n, 4);
    chk("r1_c5_arvalid", bus.m_axi_arvalid, 1'b0);
    chk("r1_c5_rready", bus.m_axi_rready, 1'b1);
    bus.m_axi_rvalid = 1'b1;
    bus.m_axi_rdata  = 32'h12345678;
    bus.m_axi_rresp  = 2'b00;
    tick();
    bus.m_axi_rvalid = 1'b0;
    chk("r1_rsp_valid", bus.rsp_valid, 1'b1);
    chk("r1_rsp_rdata", bus.rsp_rdata, 32'h12345678);
    chk("r1_rsp_resp", bus.rsp_resp, 2'b00);
    chk("r1_rready_drop", bus.m_axi_rready, 1'b0);
    tick();
    chk("r1_cmd_ready", bus.cmd_ready, 1'b1);

    // split acceptance: W at cycle 1, AW at cycle 4, slave error passed through
    drive_cmd(1'b1, 8'h10, 32'hA5A5A5A5, 4'h3);
    bus.m_axi_wready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    chk("w2_c1_awvalid", bus.m_axi_awvalid, 1'b1);
    chk("w2_c1_wvalid", bus.m_axi_wvalid, 1'b1);
    tick();
    bus.m_axi_wready = 1'b0;
    chk("w2_c2_wvalid", bus.m_axi_wvalid, 1'b0);
    chk("w2_c2_awvalid", bus.m_axi_awvalid, 1'b1);
    chk("w2_c2_awaddr", bus.m_axi_awaddr, 8'h10);
    tick();
    chk("w2_c3_awvalid", bus.m_axi_awvalid, 1'b1);
    chk("w2_c3_awaddr", bus.m_axi_awaddr, 8'h10);
    chk("w2_c3_bready", bus.m_axi_bready, 1'b0);
    tick();
    bus.m_axi_awready = 1'b1;
    chk("w2_c4_awvalid", bus.m_axi_awvalid, 1'b1);
    chk("w2_c4_bready", bus.m_axi_bready, 1'b0);
    tick();
    bus.m_axi_awready = 1'b0;
    chk("w2_c5_awvalid", bus.m_axi_awvalid, 1'b0);
    chk("w2_c5_bready", bus.m_axi_bready, 1'b1);
    bus.m_axi_bvalid = 1'b1;
    bus.m_axi_bresp  = 2'b10;
    tick();
    bus.m_axi_bvalid = 1'b0;
    chk("w2_rsp_valid", bus.rsp_valid, 1'b1);
    chk("w2_rsp_resp", bus.rsp_resp, 2'b10);
    chk("w2_rsp_rdata", bus.rsp_rdata, 32'h0);
    tick();

    // response backpressure with the next command already waiting
    bus.rsp_ready     = 1'b0;
    bus.m_axi_arready = 1'b1;
    drive_cmd(1'b0, 8'h0C, 32'h0, 4'h0);
    tick();
    bus.cmd_valid = 1'b0;
    chk("bp_arvalid", bus.m_axi_arvalid, 1'b1);
    tick();
    bus.m_axi_arready = 1'b0;
    chk("bp_rready", bus.m_axi_rready, 1'b1);
    bus.m_axi_rvalid = 1'b1;
    bus.m_axi_rdata  = 32'hCAFEF00D;
    bus.m_axi_rresp  = 2'b11;
    tick();
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_awready = 1'b1;
    bus.m_axi_wready  = 1'b1;
    drive_cmd(1'b1, 8'h20, 32'h11223344, 4'hF);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
      chk("bp_rsp_rdata", bus.rsp_rdata, 32'hCAFEF00D);
      chk("bp_rsp_resp", bus.rsp_resp, 2'b11);
      chk("bp_cmd_ready", bus.cmd_ready, 1'b0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_after_rsp_valid", bus.rsp_valid, 1'b0);
    chk("bp_after_cmd_ready", bus.cmd_ready, 1'b1);
    chk("bp_after_awvalid", bus.m_axi_awvalid, 1'b0);
    tick();
    bus.cmd_valid = 1'b0;
    chk("bp_next_awvalid", bus.m_axi_awvalid, 1'b1);
    chk("bp_next_awaddr", bus.m_axi_awaddr, 8'h20);
    chk("bp_next_cmd_ready", bus.cmd_ready, 1'b0);
    tick();
    chk("bp_next_state", dbg_state, S_WRESP);
    chk("bp_next_bready", bus.m_axi_bready, 1'b1);

    // reset pulse while waiting in WRESP
    reset = 1'b1;
    tick();
    chk("rp_bready", bus.m_axi_bready, 1'b0);
    chk("rp_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rp_state", dbg_state, S_IDLE);
    chk("rp_awvalid", bus.m_axi_awvalid, 1'b0);
    chk("rp_cmd_ready", bus.cmd_ready, 1'b0);
    reset = 1'b0;
    tick();
    chk("rp_idle_cmd_ready", bus.cmd_ready, 1'b1);
    chk("rp_no_rsp", bus.rsp_valid, 1'b0);
    drive_cmd(1'b1, 8'h30, 32'h0BADCAFE, 4'h5);
    tick();
    bus.cmd_valid = 1'b0;
    chk("rp_w_awaddr", bus.m_axi_awaddr, 8'h30);
    chk("rp_w_wdata", bus.m_axi_wdata, 32'h0BADCAFE);
    chk("rp_w_wstrb", bus.m_axi_wstrb, 4'h5);
    tick();
    chk("rp_w_bready", bus.m_axi_bready, 1'b1);
    bus.m_axi_bvalid = 1'b1;
    bus.m_axi_bresp  = 2'b01;
    tick();
    bus.m_axi_bvalid = 1'b0;
    chk("rp_w_rsp_valid", bus.rsp_valid, 1'b1);
    chk("rp_w_rsp_resp", bus.rsp_resp, 2'b01);
    tick();
    chk("rp_w_idle", dbg_state, S_IDLE);
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;

    // slave never answers the read address
    drive_cmd(1'b0, 8'h40, 32'h0, 4'h0);
    tick();
    bus.cmd_valid = 1'b0;
`ifdef AXIL_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 40 && bus.m_axi_arvalid; i++) begin
      n++;
      tick();
    end
    chk("to_arvalid_cycles", n, 16);
    chk("to_arvalid", bus.m_axi_arvalid, 1'b0);
    chk("to_rsp_valid", bus.rsp_valid, 1'b1);
    chk("to_timeout", bus.rsp_timeout, 1'b1);
    chk("to_rsp_resp", bus.rsp_resp, 2'b10);
    chk("to_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("to_state", dbg_state, S_RESP);
    tick();
    chk("to_clear", bus.rsp_timeout, 1'b0);
    chk("to_idle", dbg_state, S_IDLE);
`else
    repeat (40) tick();
    chk("nto_arvalid", bus.m_axi_arvalid, 1'b1);
    chk("nto_rsp_valid", bus.rsp_valid, 1'b0);
    chk("nto_timeout", bus.rsp_timeout, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("nto_reset_arvalid", bus.m_axi_arvalid, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
